// File: rtl/uart_rx_byte_fifo.sv
// uart_rx_byte_fifo: oversampled 8N1 receiver feeding a show-ahead byte FIFO.
// Sticky framing/overrun flags; valid/ready byte stream toward the command master.
module uart_rx_byte_fifo #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUD       = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            rx,
  output logic [7:0]                      out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            framing_error,
  output logic                            overrun,
  input  logic                            clear_errors
);

  localparam int DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW  = $clog2(OVERSAMPLE);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int LW  = AW + 1;

  localparam logic [TW-1:0] TMAX = TW'(DIV - 1);
  localparam logic [SW-1:0] SHALF = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SFULL = SW'(OVERSAMPLE - 1);
  localparam logic [LW-1:0] LFULL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state, state_nx;

  logic rx_m, rx_s, rx_d;
  logic start_det;

  logic [TW-1:0] tcnt;
  logic          tick;
  logic          tick_restart;

  logic [SW-1:0] scnt;
  logic [2:0]    bcnt;
  logic [7:0]    sh;

  logic scnt_clr, scnt_inc;
  logic bcnt_clr, shift_en;
  logic push, ferr_set;

  // Two-flop synchronizer plus one delayed copy for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  assign start_det = rx_d && !rx_s;

  assign tick = (tcnt == TMAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt <= '0;
    end else if (tick_restart || tick) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (start_det) state_nx = START;
      end
      START: begin
        if (tick && scnt == SHALF) begin
          state_nx = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick && scnt == SFULL && bcnt == 3'd7) begin
          state_nx = STOP;
        end
      end
      STOP: begin
        if (tick && scnt == SFULL) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    tick_restart = 1'b0;
    scnt_clr     = 1'b0;
    scnt_inc     = 1'b0;
    bcnt_clr     = 1'b0;
    shift_en     = 1'b0;
    push         = 1'b0;
    ferr_set     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_det) begin
          tick_restart = 1'b1;
          scnt_clr     = 1'b1;
        end
      end
      START: begin
        if (tick) begin
          if (scnt == SHALF) begin
            scnt_clr = 1'b1;
            bcnt_clr = 1'b1;
          end else begin
            scnt_inc = 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (scnt == SFULL) begin
            scnt_clr = 1'b1;
            shift_en = 1'b1;
          end else begin
            scnt_inc = 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (scnt == SFULL) begin
            scnt_clr = 1'b1;
            push     = rx_s;
            ferr_set = !rx_s;
          end else begin
            scnt_inc = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scnt <= '0;
      bcnt <= '0;
      sh   <= '0;
    end else begin
      if (scnt_clr) begin
        scnt <= '0;
      end else if (scnt_inc) begin
        scnt <= scnt + 1'b1;
      end
      if (bcnt_clr) begin
        bcnt <= '0;
      end else if (shift_en) begin
        bcnt <= bcnt + 1'b1;
      end
      if (shift_en) sh <= {rx_s, sh[7:1]};
    end
  end

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr, rptr_nx;
  logic [LW-1:0] level, level_nx;
  logic [7:0]    head_nx;
  logic          full, empty, pop, wr, ovr_set;

  assign full    = (level == LFULL);
  assign empty   = (level == '0);
  assign pop     = !empty && out_ready;
  assign wr      = push && (!full || pop);
  assign ovr_set = push && full && !pop;
  assign rptr_nx = pop ? rptr + 1'b1 : rptr;

  always_comb begin
    level_nx = level;
    if (wr && !pop) begin
      level_nx = level + 1'b1;
    end else if (pop && !wr) begin
      level_nx = level - 1'b1;
    end
  end

  // A byte landing in an emptied FIFO becomes the head before mem holds it
  always_comb begin
    head_nx = mem[rptr_nx];
    if (wr && wptr == rptr_nx) head_nx = sh;
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= sh;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      out_data <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      rptr  <= rptr_nx;
      level <= level_nx;
      if (level_nx != '0) out_data <= head_nx;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      if (ferr_set) begin
        framing_error <= 1'b1;
      end else if (clear_errors) begin
        framing_error <= 1'b0;
      end
      if (ovr_set) begin
        overrun <= 1'b1;
      end else if (clear_errors) begin
        overrun <= 1'b0;
      end
    end
  end

  assign out_valid  = !empty;
  assign fifo_level = level;

endmodule
